irq_responder: RTL and testbench
================================

IRQ_RESPONDER -- requirements
Module: irq_responder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 2: consecutive CLK_EN samples a raw IPL level must hold before it is accepted (range 1..15).
REQ-002 SHALL have parameter CLR_TIMEOUT, default 15: maximum CLK_EN samples spent in WAIT_CLR (range 1..255).
REQ-003 SHALL have parameter AUTO_ACK, default 1: 1 = block issues the source acknowledge write itself; 0 = acknowledge write suppressed.
REQ-004 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port nRESET  input  1  asynchronous active-low reset.
REQ-006 SHALL have port CLK_EN  input  1  advance enable; state, counters and input sampling change only when high.
REQ-007 SHALL have port IPL0  input  1  interrupt level bit 0 from the IRQ controller.
REQ-008 SHALL have port IPL1  input  1  interrupt level bit 1 from the IRQ controller.
REQ-009 SHALL have port MASK  input  2  CPU interrupt mask; level accepted only if greater than MASK.
REQ-010 SHALL have port IACK_STB  input  1  CPU begins interrupt acknowledge; sampled on CLK_EN cycles.
REQ-011 SHALL have port IRQ_PEND  output  1  interrupt request to CPU.
REQ-012 SHALL have port INT_LEVEL  output  2  level being requested/serviced.
REQ-013 SHALL have port VEC_VALID  output  1  VECTOR valid strobe.
REQ-014 SHALL have port VECTOR  output  8  autovector number.
REQ-015 SHALL have port WR_ACK  output  1  acknowledge write strobe to IRQ controller.
REQ-016 SHALL have port ACK_BITS  output  3  one-hot source clear: bit0 level 3 (reset IRQ), bit1 level 2 (timer), bit2 level 1 (VBL).

Function
REQ-017 SHALL form raw level L = {IPL1,IPL0}; 0 = no interrupt, 3 = highest.
REQ-018 SHALL update filtered level FLT to L when L has been equal on STABLE_CNT consecutive CLK_EN samples; any change of L restarts the count; FLT otherwise holds.
REQ-019 SHALL implement FSM states IDLE, PEND, VECT, ACK, WAIT_CLR; all transitions only on CLK_EN cycles.
REQ-020 IDLE: when FLT > MASK (FLT != 0), SHALL register INT_LEVEL = FLT and enter PEND next enabled cycle.
REQ-021 PEND: IRQ_PEND SHALL be 1 exactly while in PEND.
REQ-022 PEND: FLT rising above INT_LEVEL SHALL update INT_LEVEL; FLT <= MASK SHALL cancel to IDLE with no VEC_VALID or WR_ACK.
REQ-023 PEND with IACK_STB=1 SHALL enter VECT, using INT_LEVEL held at the start of that cycle even if FLT changes in the same cycle; IACK_STB has priority over cancel.
REQ-024 VECT: SHALL drive VEC_VALID=1 and VECTOR = 8'h18 + INT_LEVEL (0x19/0x1A/0x1B) for one enabled cycle, then enter ACK.
REQ-025 ACK: with AUTO_ACK=1, SHALL drive WR_ACK=1 with ACK_BITS per REQ-016 for one enabled cycle; with AUTO_ACK=0 WR_ACK stays 0; then enter WAIT_CLR.
REQ-026 WAIT_CLR: SHALL return to IDLE when FLT != INT_LEVEL or after CLR_TIMEOUT enabled samples, whichever first; timeout counter cleared on entry.
REQ-027 IACK_STB outside PEND SHALL be ignored.
REQ-028 With CLK_EN low, all outputs and state SHALL hold; strobes stretch until the next enabled cycle.
REQ-029 ACK_BITS and VECTOR SHALL be 0 outside their strobe cycles.

Reset
REQ-030 nRESET low SHALL immediately force IDLE, FLT=0, filter and timeout counters 0, IRQ_PEND=0, INT_LEVEL=0, VEC_VALID=0, VECTOR=0, WR_ACK=0, ACK_BITS=0.
REQ-031 Reset mid-sequence (PEND/VECT/ACK) SHALL abort with no further strobes; after release, a still-present level re-filters from count 0.

Verification
REQ-032 CLK_EN=1, MASK=0, L=1 held -> FLT=1 after 2 samples, IRQ_PEND=1; IACK_STB -> VECTOR=0x19, then WR_ACK with ACK_BITS=3'b100.
REQ-033 L=2 pulsed for one sample only -> FLT stays 0, IRQ_PEND never asserts.
REQ-034 MASK=2, L=2 -> no IRQ_PEND; L=3 -> IRQ_PEND, VECTOR=0x1B, ACK_BITS=3'b001.
REQ-035 PEND at level 1, L rises to 2 before IACK_STB -> INT_LEVEL=2, VECTOR=0x1A, ACK_BITS=3'b010; L to 0 before IACK_STB -> back to IDLE, no strobes.
REQ-036 AUTO_ACK=0, L=1 held after IACK -> no WR_ACK; WAIT_CLR exits after 15 samples and IRQ_PEND reasserts.
REQ-037 CLK_EN toggling 1-of-4 cycles -> identical sequence at quarter rate; nRESET asserted in VECT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/irq_responder.sv
// Interrupt responder: debounces the IPL level, requests the CPU, serves the
// autovector during acknowledge and optionally clears the interrupt source.
module irq_responder #(
  parameter int unsigned STABLE_CNT  = 2,
  parameter int unsigned CLR_TIMEOUT = 15,
  parameter int unsigned AUTO_ACK    = 1
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       CLK_EN,
  input  logic       IPL0,
  input  logic       IPL1,
  input  logic [1:0] MASK,
  input  logic       IACK_STB,
  output logic       IRQ_PEND,
  output logic [1:0] INT_LEVEL,
  output logic       VEC_VALID,
  output logic [7:0] VECTOR,
  output logic       WR_ACK,
  output logic [2:0] ACK_BITS
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CNT);
  localparam logic [7:0] TMO_LAST = 8'(CLR_TIMEOUT - 1);
  localparam logic [7:0] VEC_BASE = 8'h18;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    VECT,
    ACK,
    WAIT_CLR
  } state_e;

  logic [1:0] raw;
  logic [1:0] samp_q, samp_d;
  logic [3:0] stab_q, stab_d;
  logic [1:0] flt_q, flt_d;
  state_e     state_q, state_d;
  logic [1:0] int_level_q, int_level_d;
  logic       irq_pend_q, irq_pend_d;
  logic       vec_valid_q, vec_valid_d;
  logic [7:0] vector_q, vector_d;
  logic       wr_ack_q, wr_ack_d;
  logic [2:0] ack_bits_q, ack_bits_d;
  logic [7:0] tmo_q, tmo_d;

  assign raw = {IPL1, IPL0};

  function automatic logic [2:0] ack_onehot(input logic [1:0] lvl);
    logic [2:0] oh;
    oh = '0;
    case (lvl)
      2'd3:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd1:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Level filter: stab_q counts consecutive equal samples (saturating);
  // a zero count after reset forces the first sample to start a new run.
  always_comb begin
    samp_d = samp_q;
    stab_d = stab_q;
    flt_d  = flt_q;
    if (CLK_EN) begin
      if ((raw == samp_q) && (stab_q != 4'd0)) begin
        if (stab_q < STABLE_N) begin
          stab_d = stab_q + 4'd1;
        end
      end else begin
        samp_d = raw;
        stab_d = 4'd1;
      end
      if (stab_d >= STABLE_N) begin
        flt_d = raw;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    int_level_d = int_level_q;
    irq_pend_d  = irq_pend_q;
    vec_valid_d = vec_valid_q;
    vector_d    = vector_q;
    wr_ack_d    = wr_ack_q;
    ack_bits_d  = ack_bits_q;
    tmo_d       = tmo_q;
    if (CLK_EN) begin
      case (state_q)
        IDLE: begin
          if ((flt_q != 2'd0) && (flt_q > MASK)) begin
            state_d     = PEND;
            int_level_d = flt_q;
            irq_pend_d  = 1'b1;
          end
        end
        PEND: begin
          // Acknowledge wins over cancel and over a same-cycle level raise.
          if (IACK_STB) begin
            state_d     = VECT;
            irq_pend_d  = 1'b0;
            vec_valid_d = 1'b1;
            vector_d    = VEC_BASE + 8'(int_level_q);
          end else if (flt_q <= MASK) begin
            state_d    = IDLE;
            irq_pend_d = 1'b0;
          end else if (flt_q > int_level_q) begin
            int_level_d = flt_q;
          end
        end
        VECT: begin
          state_d     = ACK;
          vec_valid_d = 1'b0;
          vector_d    = '0;
          if (AUTO_ACK != 0) begin
            wr_ack_d   = 1'b1;
            ack_bits_d = ack_onehot(int_level_q);
          end
        end
        ACK: begin
          state_d    = WAIT_CLR;
          wr_ack_d   = 1'b0;
          ack_bits_d = '0;
          tmo_d      = '0;
        end
        WAIT_CLR: begin
          if ((flt_q != int_level_q) || (tmo_q >= TMO_LAST)) begin
            state_d = IDLE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      samp_q      <= '0;
      stab_q      <= '0;
      flt_q       <= '0;
      state_q     <= IDLE;
      int_level_q <= '0;
      irq_pend_q  <= 1'b0;
      vec_valid_q <= 1'b0;
      vector_q    <= '0;
      wr_ack_q    <= 1'b0;
      ack_bits_q  <= '0;
      tmo_q       <= '0;
    end else begin
      samp_q      <= samp_d;
      stab_q      <= stab_d;
      flt_q       <= flt_d;
      state_q     <= state_d;
      int_level_q <= int_level_d;
      irq_pend_q  <= irq_pend_d;
      vec_valid_q <= vec_valid_d;
      vector_q    <= vector_d;
      wr_ack_q    <= wr_ack_d;
      ack_bits_q  <= ack_bits_d;
      tmo_q       <= tmo_d;
    end
  end

  assign IRQ_PEND  = irq_pend_q;
  assign INT_LEVEL = int_level_q;
  assign VEC_VALID = vec_valid_q;
  assign VECTOR    = vector_q;
  assign WR_ACK    = wr_ack_q;
  assign ACK_BITS  = ack_bits_q;

endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder: vector table plus multi-cycle sequences
// (suppressed acknowledge, quarter-rate enable, reset during vectoring).
module tb_irq_responder;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       CLK_EN;
  logic       IPL0, IPL1;
  logic [1:0] MASK;
  logic       IACK_STB;

  logic       irq_pend, vec_valid, wr_ack;
  logic [1:0] int_level;
  logic [7:0] vector;
  logic [2:0] ack_bits;

  logic       na_irq_pend, na_vec_valid, na_wr_ack;
  logic [1:0] na_int_level;
  logic [7:0] na_vector;
  logic [2:0] na_ack_bits;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  irq_responder #(.STABLE_CNT(2), .CLR_TIMEOUT(15), .AUTO_ACK(1)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN(CLK_EN), .IPL0(IPL0), .IPL1(IPL1),
    .MASK(MASK), .IACK_STB(IACK_STB), .IRQ_PEND(irq_pend), .INT_LEVEL(int_level),
    .VEC_VALID(vec_valid), .VECTOR(vector), .WR_ACK(wr_ack), .ACK_BITS(ack_bits)
  );

  irq_responder #(.STABLE_CNT(2), .CLR_TIMEOUT(15), .AUTO_ACK(0)) dut_na (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN(CLK_EN), .IPL0(IPL0), .IPL1(IPL1),
    .MASK(MASK), .IACK_STB(IACK_STB), .IRQ_PEND(na_irq_pend), .INT_LEVEL(na_int_level),
    .VEC_VALID(na_vec_valid), .VECTOR(na_vector), .WR_ACK(na_wr_ack), .ACK_BITS(na_ack_bits)
  );

  typedef struct {
    logic [1:0] l;
    logic [1:0] mask;
    logic       iack;
    logic       pend;
    logic [1:0] lvl;
    logic       vv;
    logic [7:0] vec;
    logic       wr;
    logic [2:0] bits;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] l, input logic [1:0] mask, input logic iack,
                              input logic pend, input logic [1:0] lvl, input logic vv,
                              input logic [7:0] vec, input logic wr, input logic [2:0] bits);
    vec_t v;
    v.l = l; v.mask = mask; v.iack = iack; v.pend = pend; v.lvl = lvl;
    v.vv = vv; v.vec = vec; v.wr = wr; v.bits = bits;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_l(input logic [1:0] l);
    {IPL1, IPL0} = l;
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    step(2);
    nRESET = 1'b1;
  endtask

  task automatic chk_outs(input string nm, input logic pend, input logic vv, input logic [7:0] vec,
                          input logic wr, input logic [2:0] bits);
    chk({nm, " pend"}, 32'(irq_pend), 32'(pend));
    chk({nm, " vv"},   32'(vec_valid), 32'(vv));
    chk({nm, " vec"},  32'(vector), 32'(vec));
    chk({nm, " wr"},   32'(wr_ack), 32'(wr));
    chk({nm, " bits"}, 32'(ack_bits), 32'(bits));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main sequence, level 1 serviced
    tbl.push_back(mk(1,0,0, 0,0,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 0,0,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,1, 0,1,1,8'h19,0,3'b000));
    tbl.push_back(mk(1,0,0, 0,1,0,8'h00,1,3'b100));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    // One-sample glitch at level 2
    tbl.push_back(mk(2,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    // Mask 2: level 2 blocked, level 3 serviced
    tbl.push_back(mk(2,2,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,2,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,2,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(3,2,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(3,2,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(3,2,0, 1,3,0,8'h00,0,3'b000));
    tbl.push_back(mk(3,2,1, 0,3,1,8'h1B,0,3'b000));
    tbl.push_back(mk(3,2,0, 0,3,0,8'h00,1,3'b001));
    tbl.push_back(mk(0,2,0, 0,3,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,2,0, 0,3,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,2,0, 0,3,0,8'h00,0,3'b000));
    // Level raise 1 -> 2 while pending
    tbl.push_back(mk(1,0,0, 0,3,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 0,3,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 1,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,1, 0,2,1,8'h1A,0,3'b000));
    tbl.push_back(mk(2,0,0, 0,2,0,8'h00,1,3'b010));
    tbl.push_back(mk(0,0,0, 0,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,2,0,8'h00,0,3'b000));
    // Cancel: level drops to 0 before acknowledge
    tbl.push_back(mk(1,0,0, 0,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 0,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,1,0,8'h00,0,3'b000));
    // Acknowledge in the same cycle the filtered level rises
    tbl.push_back(mk(1,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(1,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 1,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,1, 0,1,1,8'h19,0,3'b000));
    tbl.push_back(mk(2,0,0, 0,1,0,8'h00,1,3'b100));
    tbl.push_back(mk(2,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 0,1,0,8'h00,0,3'b000));
    tbl.push_back(mk(2,0,0, 1,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,1, 0,2,1,8'h1A,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,2,0,8'h00,1,3'b010));
    tbl.push_back(mk(0,0,0, 0,2,0,8'h00,0,3'b000));
    tbl.push_back(mk(0,0,0, 0,2,0,8'h00,0,3'b000));
    // Acknowledge strobe outside PEND is ignored
    tbl.push_back(mk(0,0,1, 0,2,0,8'h00,0,3'b000));

    CLK_EN = 1'b1; MASK = 2'd0; IACK_STB = 1'b0; set_l(2'd0);
    nRESET = 1'b0;
    step(2);
    chk_outs("reset", 0, 0, 8'h00, 0, 3'b000);
    chk("reset lvl", 32'(int_level), 32'd0);
    nRESET = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      set_l(tbl[i].l);
      MASK     = tbl[i].mask;
      IACK_STB = tbl[i].iack;
      step(1);
      chk_outs($sformatf("row%0d", i), tbl[i].pend, tbl[i].vv, tbl[i].vec, tbl[i].wr, tbl[i].bits);
      chk($sformatf("row%0d lvl", i), 32'(int_level), 32'(tbl[i].lvl));
    end
    IACK_STB = 1'b0;

    // Suppressed acknowledge: WAIT_CLR ends on timeout, request re-raised
    begin
      int  n;
      bit  seen_wr;
      set_l(2'd0); MASK = 2'd0;
      do_reset();
      set_l(2'd1);
      step(3);
      chk("na pend", 32'(na_irq_pend), 32'd1);
      IACK_STB = 1'b1;
      step(1);
      IACK_STB = 1'b0;
      chk("na vec", 32'(na_vector), 32'h19);
      step(1);
      chk("na wr", 32'(na_wr_ack), 32'd0);
      chk("na bits", 32'(na_ack_bits), 32'd0);
      chk("auto wr", 32'(wr_ack), 32'd1);
      step(1);
      n = 0;
      seen_wr = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        step(1);
        if (na_wr_ack) seen_wr = 1'b1;
        if (na_irq_pend) begin
          n = i;
          break;
        end
      end
      chk("na timeout cycles", 32'(n), 32'd16);
      chk("na no wr", 32'(seen_wr), 32'd0);
      chk("na relevel", 32'(na_int_level), 32'd1);
    end

    // Quarter-rate enable: same sequence, strobes stretched across idle cycles
    begin
      logic       e_pend[5] = '{0, 0, 1, 0, 0};
      logic       e_vv[5]   = '{0, 0, 0, 1, 0};
      logic [7:0] e_vec[5]  = '{8'h00, 8'h00, 8'h00, 8'h19, 8'h00};
      logic       e_wr[5]   = '{0, 0, 0, 0, 1};
      logic [2:0] e_bits[5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
      set_l(2'd0); CLK_EN = 1'b1;
      do_reset();
      set_l(2'd1);
      for (int g = 0; g < 5; g++) begin
        IACK_STB = (g == 3);
        CLK_EN   = 1'b0;
        step(3);
        if (g > 0)
          chk_outs($sformatf("qr hold%0d", g), e_pend[g-1], e_vv[g-1], e_vec[g-1], e_wr[g-1], e_bits[g-1]);
        else
          chk_outs("qr hold0", 0, 0, 8'h00, 0, 3'b000);
        CLK_EN = 1'b1;
        step(1);
        chk_outs($sformatf("qr en%0d", g), e_pend[g], e_vv[g], e_vec[g], e_wr[g], e_bits[g]);
      end
      IACK_STB = 1'b0;
    end

    // Reset asserted while in VECT, then level re-filters from scratch
    set_l(2'd0);
    do_reset();
    set_l(2'd1);
    step(3);
    IACK_STB = 1'b1;
    step(1);
    IACK_STB = 1'b0;
    chk("vect vv", 32'(vec_valid), 32'd1);
    #2;
    nRESET = 1'b0;
    #1;
    chk_outs("async rst", 0, 0, 8'h00, 0, 3'b000);
    chk("async rst lvl", 32'(int_level), 32'd0);
    step(2);
    nRESET = 1'b1;
    step(2);
    chk_outs("refilt2", 0, 0, 8'h00, 0, 3'b000);
    step(1);
    chk_outs("refilt3", 1, 0, 8'h00, 0, 3'b000);
    chk("refilt lvl", 32'(int_level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
